// File: rtl/lookupflow_req_pkg.sv
// lookupflow_req shared definitions
// FSM encoding, GMII framing bytes, header geometry
package lookupflow_req_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HDR,
    LOOKUP,
    DRAIN
  } state_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam int HDR_LEN = 12;
  localparam int TUPLE_W = 8 * HDR_LEN;

  localparam logic [3:0] HDR_LAST = 4'(HDR_LEN - 1);

  function automatic logic [3:0] port_bit(
    input logic [3:0] p
  );
    return 4'b1 << p;
  endfunction

endpackage

// File: rtl/lookupflow_req_hdr.sv
// lookupflow_req header capture
// Preamble/SFD byte detect and 12-byte {dst,src} shift
module lookupflow_req_hdr
  import lookupflow_req_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               gmii_rx_dv,
  input  logic [7:0]         gmii_rxd,
  input  state_t             state,
  output logic               is_pre,
  output logic               is_sfd,
  output logic               hdr_done,
  output logic [TUPLE_W-1:0] tuple
);

  logic [3:0] cnt;
  logic       cap;

  assign cap      = (state == HDR) && gmii_rx_dv;
  assign is_pre   = (gmii_rxd == PRE_BYTE);
  assign is_sfd   = (gmii_rxd == SFD_BYTE);
  assign hdr_done = cap && (cnt == HDR_LAST);

  // header byte index; idle at zero outside capture
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (cap && !hdr_done) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // shift in header bytes; byte 0 reaches the top octet
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tuple <= '0;
    end else if (cap) begin
      tuple <= {tuple[TUPLE_W-9:0], gmii_rxd};
    end
  end

endmodule

// File: rtl/lookupflow_req.sv
// lookupflow_req: frame header -> flow-table lookup
// Optional stats ports under LOOKUPFLOW_REQ_STATS_EN
module lookupflow_req
  import lookupflow_req_pkg::*;
#(
  parameter logic [3:0] PORT_NUM  = 4'h0,
  parameter logic [3:0] BROADCAST = ~(4'b1 << PORT_NUM),
  parameter int         TIMEOUT   = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         gmii_rx_dv,
  input  logic [7:0]   gmii_rxd,
  output logic         req,
  output logic [95:0]  tuple,
  input  logic         ack,
  input  logic [3:0]   fwd_port,
`ifdef LOOKUPFLOW_REQ_STATS_EN
  output logic [15:0]  lookup_cnt,
  output logic [15:0]  timeout_cnt,
`endif
  output logic [3:0]   dst_port,
  output logic         dst_valid,
  output logic         dst_timeout
);

  localparam logic [3:0] SELF    = port_bit(PORT_NUM);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] to_cnt;
  logic       is_pre;
  logic       is_sfd;
  logic       hdr_done;
  logic       ack_hit;
  logic       to_hit;

  lookupflow_req_hdr u_hdr (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rxd   (gmii_rxd),
    .state      (state),
    .is_pre     (is_pre),
    .is_sfd     (is_sfd),
    .hdr_done   (hdr_done),
    .tuple      (tuple)
  );

  // ack has priority over an expiring timeout
  assign ack_hit = (state == LOOKUP) && ack;
  assign to_hit  = (state == LOOKUP) && !ack
                && (to_cnt == TO_LAST);

  // framing FSM, lookup handshake and result registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      req         <= 1'b0;
      to_cnt      <= '0;
      dst_port    <= '0;
      dst_valid   <= 1'b0;
      dst_timeout <= 1'b0;
    end else begin
      dst_valid   <= 1'b0;
      dst_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            state <= is_pre ? PREAMBLE : DRAIN;
          end
        end
        PREAMBLE: begin
          unique case (1'b1)
            !gmii_rx_dv: state <= IDLE;
            is_sfd:      state <= HDR;
            is_pre:      state <= PREAMBLE;
            default:     state <= DRAIN;
          endcase
        end
        HDR: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (hdr_done) begin
            state  <= LOOKUP;
            req    <= 1'b1;
            to_cnt <= '0;
          end
        end
        LOOKUP: begin
          unique case (1'b1)
            ack_hit: begin
              req       <= 1'b0;
              dst_port  <= fwd_port & ~SELF;
              dst_valid <= 1'b1;
              state     <= gmii_rx_dv ? DRAIN : IDLE;
            end
            to_hit: begin
              req         <= 1'b0;
              dst_port    <= BROADCAST;
              dst_valid   <= 1'b1;
              dst_timeout <= 1'b1;
              state       <= gmii_rx_dv ? DRAIN : IDLE;
            end
            default: to_cnt <= to_cnt + 8'd1;
          endcase
        end
        DRAIN: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOOKUPFLOW_REQ_STATS_EN
  // lookup and timeout event counters, free-running wrap
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lookup_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (ack_hit) begin
        lookup_cnt <= lookup_cnt + 16'd1;
      end
      if (to_hit) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/lookupflow_req.md
LOOKUPFLOW_REQ -- requirements
Module: lookupflow_req

Interface
REQ-001 Parameter PORT_NUM, default 4'h0: index of the port this requester serves.
REQ-002 Parameter BROADCAST, default ~(4'b1 << PORT_NUM): destination mask used on lookup timeout.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for ack after req rises (range 2-255).
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 gmii_rx_dv  in  1  receive data valid, byte-wide frame stream including preamble/SFD.
REQ-007 gmii_rxd  in  8  receive byte.
REQ-008 req  out  1  lookup request to flow table.
REQ-009 tuple  out  96  {dst MAC, src MAC}; dst MAC in [95:48].
REQ-010 ack  in  1  flow-table acknowledge; registered response, high while req high.
REQ-011 fwd_port  in  4  flow-table result, valid when ack high.
REQ-012 dst_port  out  4  resolved destination mask.
REQ-013 dst_valid  out  1  one-cycle pulse; dst_port valid.
REQ-014 dst_timeout  out  1  qualifies dst_valid; high when result came from timeout.

Function
REQ-015 FSM states: IDLE, PREAMBLE, HDR, LOOKUP, DRAIN.
REQ-016 IDLE -> PREAMBLE when gmii_rx_dv=1 and gmii_rxd=8'h55.
REQ-017 IDLE with gmii_rx_dv=1 and byte other than 8'h55 -> DRAIN.
REQ-018 PREAMBLE: 8'h55 stays; 8'hD5 -> HDR; any other byte -> DRAIN.
REQ-019 HDR: capture 12 bytes with a 4-bit counter; byte k (0-11) after SFD into tuple[95-8k -: 8].
REQ-020 HDR -> LOOKUP on 12th byte; req rises the next cycle with tuple stable.
REQ-021 gmii_rx_dv=0 in PREAMBLE or HDR (runt): -> IDLE, no req, no dst_valid.
REQ-022 tuple SHALL NOT change while req=1.
REQ-023 LOOKUP: req held high until ack sampled high or timeout; req low the cycle after.
REQ-024 On ack: dst_port <= fwd_port & ~(4'b1 << PORT_NUM); dst_valid=1 and dst_timeout=0 for one cycle.
REQ-025 Timeout counter starts at 0 on req rise; reaching TIMEOUT-1 without ack: dst_port <= BROADCAST, dst_valid=1, dst_timeout=1.
REQ-026 ack and timeout in same cycle: ack wins.
REQ-027 Nominal latency: dst_valid 3 cycles after the 12th header byte (req, ack, result).
REQ-028 LOOKUP exit: -> DRAIN if gmii_rx_dv=1, else IDLE.
REQ-029 Frame ending while in LOOKUP: lookup completes; no new frame accepted until LOOKUP exits.
REQ-030 DRAIN -> IDLE when gmii_rx_dv=0.
REQ-031 dst_port holds its last value between dst_valid pulses.

Reset
REQ-032 On sys_rst_n=0: FSM=IDLE, req=0, tuple=0, dst_port=0, dst_valid=0, dst_timeout=0, counters=0.
REQ-033 Reset mid-lookup drops req immediately; no dst_valid is generated for that frame.

Configuration
REQ-034 Macro LOOKUPFLOW_REQ_STATS_EN defined: adds outputs lookup_cnt[15:0] (increments per ack) and timeout_cnt[15:0] (increments per timeout); both wrap at 16'hFFFF -> 0 and reset to 0.
REQ-035 Macro undefined: stats ports and counters absent; other behaviour identical.

Structure
REQ-036 Shared package holds FSM state encoding, preamble/SFD byte constants (8'h55, 8'hD5), header length 12.
REQ-037 One sub-module, lookupflow_req_hdr (preamble/SFD detect and 12-byte tuple shift); FSM, handshake, timeout in top.

Verification
REQ-038 7x55, D5, dst 00:00:00:00:00:02, src 00:00:00:00:00:01, table acks 4'b0100 -> tuple 96'h000000000002_000000000001, dst_port 4'b0100, dst_timeout 0.
REQ-039 PORT_NUM=0, dst FF:FF:FF:FF:FF:FF, table returns 4'b1110 -> dst_port 4'b1110; table returns 4'b0001 -> dst_port 4'b0000.
REQ-040 ack held 0 -> req high 16 cycles, dst_port=BROADCAST, dst_timeout=1, timeout_cnt=1 when STATS_EN.
REQ-041 gmii_rx_dv drops after 6th header byte -> no req, next valid frame resolves normally.
REQ-042 Preamble byte 8'h5A -> DRAIN, no req until rx_dv low and new frame.
REQ-043 sys_rst_n low for 1 cycle while req=1 -> req=0 same cycle, no dst_valid, next frame resolves normally.
